iob_bus_merge: RTL

Merges N native-interface master buses (e.g. `ibus_req` and `dbus_req` from the CPU wrapper) onto one native slave bus feeding shared memory or the peripheral split. It is the stage directly downstream of the CPU wrapper. It arbitrates between masters, locks the grant for the duration of one transfer, and routes the slave response back to the granted master only. No requests are buffered and no bus latency is added beyond the arbitration decision.

---
 rtl/iob_bus_merge_pkg.sv | 23 ++
 rtl/iob_merge_arb.sv | 40 ++++
 rtl/iob_bus_merge.sv | 61 ++++++
 3 files changed

// File: rtl/iob_bus_merge_pkg.sv
// iob_bus_merge_pkg: native bus field layout and merge FSM states.
package iob_bus_merge_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    localparam int WSTRB_LSB = 0;
    localparam int READY_LSB = 0;
    localparam int RDATA_LSB = 1;
    function automatic int req_w(int aw, int dw);
        return 1 + aw + dw + dw / 8;
    endfunction
    function automatic int resp_w(int dw);
        return dw + 1;
    endfunction
    // request slice from MSB: valid, address, wdata, wstrb
    function automatic int valid_lsb(int aw, int dw);
        return aw + dw + dw / 8;
    endfunction
    function automatic int address_lsb(int dw);
        return dw + dw / 8;
    endfunction
    function automatic int wdata_lsb(int dw);
        return dw / 8;
    endfunction
endpackage

// File: rtl/iob_merge_arb.sv
// iob_merge_arb: combinational winner select among valid masters.
// IOB_MERGE_RR_EN selects round-robin from last+1; otherwise the lowest index wins.
module iob_merge_arb
#(
    parameter int  N  = 2,
    localparam int GW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
`ifdef IOB_MERGE_RR_EN
    input  logic [GW-1:0] last,
`endif
    output logic [GW-1:0] winner,
    output logic          found
);
`ifdef IOB_MERGE_RR_EN
    logic [GW-1:0] idx;
`endif
    always_comb begin
        winner = '0;
        found  = 1'b0;
`ifdef IOB_MERGE_RR_EN
        idx    = '0;
        // scan backwards so the first valid index after last is the one kept
        for (int k = N; k >= 1; k--) begin
            idx = GW'((int'(last) + k) % N);
            if (valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[GW'(k)]) begin
                winner = GW'(k);
                found  = 1'b1;
            end
        end
`endif
    end
endmodule

// File: rtl/iob_bus_merge.sv
// iob_bus_merge: merges N native master buses onto one slave bus, one locked transfer at a time.
// Define IOB_MERGE_RR_EN for round-robin arbitration; default is fixed priority.
module iob_bus_merge
    import iob_bus_merge_pkg::*;
#(
    parameter int  N_MASTERS = 2,
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 32,
    localparam int REQ_W     = req_w(ADDR_W, DATA_W),
    localparam int RESP_W    = resp_w(DATA_W),
    localparam int GW        = $clog2(N_MASTERS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp
);
    localparam int VLSB = valid_lsb(ADDR_W, DATA_W);
    state_t               state;
    logic [GW-1:0]        grant, winner, sel;
    logic [N_MASTERS-1:0] valids;
    logic [REQ_W-1:0]     reqs [N_MASTERS];
    logic                 found, active, done;
    for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
        assign reqs[i]   = m_req[i*REQ_W +: REQ_W];
        assign valids[i] = reqs[i][VLSB];
        assign m_resp[i*RESP_W +: RESP_W] = (done && sel == GW'(i)) ? s_resp : '0;
    end
`ifdef IOB_MERGE_RR_EN
    logic [GW-1:0] last;
    iob_merge_arb #(.N(N_MASTERS)) u_arb (.valid(valids), .last(last), .winner(winner), .found(found));
`else
    iob_merge_arb #(.N(N_MASTERS)) u_arb (.valid(valids), .winner(winner), .found(found));
`endif
    assign sel    = (state == BUSY) ? grant : winner;
    assign active = !rst && (state == BUSY || found);
    assign s_req  = active ? reqs[sel] : '0;
    // an aborted master leaves s_req idle, so a stray ready is never routed
    assign done   = s_req[VLSB] && s_resp[READY_LSB];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
`ifdef IOB_MERGE_RR_EN
            last  <= GW'(N_MASTERS - 1);
`endif
        end else if (state == IDLE) begin
            if (found) begin
                grant <= winner;
`ifdef IOB_MERGE_RR_EN
                last  <= winner;
`endif
                state <= done ? IDLE : BUSY;
            end
        end else begin
            state <= (s_req[VLSB] && !s_resp[READY_LSB]) ? BUSY : IDLE;
        end
    end
endmodule
